// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt controller: N-line edge capture, maskable pending bits, fixed-priority
// selection with optional vectored dispatch, and the EPC/EHBR/Status/Cause registers.
module cp0_irq_ctrl #(
  parameter int          NUM_IRQ    = 4,
  parameter int          VECTORED   = 0,
  parameter int          VEC_SHIFT  = 4,
  parameter bit          IE_RESET   = 1'b1,
  parameter logic [31:0] EHBR_RESET = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         oper,
  input  logic [4:0]         addr_r,
  output logic [31:0]        data_r,
  input  logic [4:0]         addr_w,
  input  logic [31:0]        data_w,
  input  logic               ir_en,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [31:0]        ret_addr,
  output logic               jump_en,
  output logic [31:0]        jump_addr,
  output logic               irq_active
);

  localparam logic [1:0] OP_MTC0 = 2'b10;
  localparam logic [1:0] OP_ERET = 2'b11;
  localparam logic [4:0] A_EPC    = 5'd2;
  localparam logic [4:0] A_EHBR   = 5'd3;
  localparam logic [4:0] A_STATUS = 5'd12;
  localparam logic [4:0] A_CAUSE  = 5'd13;

  logic [31:0]        epc_reg;
  logic [31:0]        ehbr_reg;
  logic               ie_reg;
  logic               exl_reg;
  logic [NUM_IRQ-1:0] im_reg;
  logic [NUM_IRQ-1:0] ip_reg;
  logic [NUM_IRQ-1:0] ip_next;
  logic [2:0]         code_reg;
  logic [NUM_IRQ-1:0] irq_prev_reg;
  logic [31:0]        jump_addr_reg;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] ack;
  logic [NUM_IRQ-1:0] w1c;
  logic               take;
  logic               eret;
  logic               mtc0;
  logic [2:0]         sel;
  logic [31:0]        vec_addr;
  logic [31:0]        jump_target;
  logic [31:0]        status_word;
  logic [31:0]        cause_word;

  assign rise = irq_in & ~irq_prev_reg;
  assign pend = ip_reg & im_reg;
  assign take = ir_en & ie_reg & ~exl_reg & (|pend);
  // A take swallows whatever CP0 operation the pipeline issued in the same cycle.
  assign eret = (oper == OP_ERET) & ~take;
  assign mtc0 = (oper == OP_MTC0) & ~take;

  // Scan from the top so the lowest pending index is the one left in sel.
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) sel = 3'(i);
    end
  end

  always_comb begin
    vec_addr = ehbr_reg;
    if (VECTORED != 0) vec_addr = ehbr_reg + (32'(sel) << VEC_SHIFT);
  end

  assign jump_target = take ? vec_addr : epc_reg;
  assign jump_en     = take | eret;
  assign jump_addr   = jump_en ? jump_target : jump_addr_reg;
  assign irq_active  = exl_reg;

  // Per-line pending update: a fresh rising edge beats both W1C and auto-acknowledge.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_line
      assign ack[gi]     = take && (sel == 3'(gi));
      assign w1c[gi]     = mtc0 && (addr_w == A_CAUSE) && data_w[8 + gi];
      assign ip_next[gi] = rise[gi] | (ip_reg[gi] & ~(ack[gi] | w1c[gi]));
    end
  endgenerate

  always_comb begin
    status_word                = '0;
    status_word[0]             = ie_reg;
    status_word[1]             = exl_reg;
    status_word[8 +: NUM_IRQ]  = im_reg;
    cause_word                 = '0;
    cause_word[8 +: NUM_IRQ]   = ip_reg;
    cause_word[4:2]            = code_reg;
  end

  always_comb begin
    case (addr_r)
      A_EPC:    data_r = epc_reg;
      A_EHBR:   data_r = ehbr_reg;
      A_STATUS: data_r = status_word;
      A_CAUSE:  data_r = cause_word;
      default:  data_r = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      epc_reg       <= '0;
      ehbr_reg      <= EHBR_RESET;
      ie_reg        <= IE_RESET;
      exl_reg       <= 1'b0;
      im_reg        <= '1;
      ip_reg        <= '0;
      code_reg      <= '0;
      irq_prev_reg  <= '0;
      jump_addr_reg <= '0;
    end else begin
      irq_prev_reg <= irq_in;
      ip_reg       <= ip_next;
      if (jump_en) jump_addr_reg <= jump_target;
      if (take) begin
        epc_reg  <= ret_addr;
        exl_reg  <= 1'b1;
        code_reg <= sel;
      end else begin
        if (eret) exl_reg <= 1'b0;
        if (mtc0) begin
          case (addr_w)
            A_EPC:  epc_reg  <= data_w;
            A_EHBR: ehbr_reg <= data_w;
            A_STATUS: begin
              ie_reg  <= data_w[0];
              exl_reg <= data_w[1];
              im_reg  <= data_w[8 +: NUM_IRQ];
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed bench for cp0_irq_ctrl: a single-handler and a vectored instance share stimulus,
// so every step checks both dispatch modes against hand-computed values.
`timescale 1ns/1ps
module tb_cp0_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  oper;
  logic [4:0]  addr_r;
  logic [4:0]  addr_w;
  logic [31:0] data_w;
  logic        ir_en;
  logic [3:0]  irq_in;
  logic [31:0] ret_addr;
  logic [31:0] data_r0, data_r1;
  logic        jump_en0, jump_en1;
  logic [31:0] jump_addr0, jump_addr1;
  logic        irq_active0, irq_active1;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  cp0_irq_ctrl #(.NUM_IRQ(4), .VECTORED(0), .VEC_SHIFT(4), .IE_RESET(1'b1), .EHBR_RESET(32'h100)) dut0 (
    .clk(clk), .rst(rst), .oper(oper), .addr_r(addr_r), .data_r(data_r0),
    .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .irq_in(irq_in),
    .ret_addr(ret_addr), .jump_en(jump_en0), .jump_addr(jump_addr0), .irq_active(irq_active0)
  );

  cp0_irq_ctrl #(.NUM_IRQ(4), .VECTORED(1), .VEC_SHIFT(4), .IE_RESET(1'b1), .EHBR_RESET(32'h200)) dut1 (
    .clk(clk), .rst(rst), .oper(oper), .addr_r(addr_r), .data_r(data_r1),
    .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .irq_in(irq_in),
    .ret_addr(ret_addr), .jump_en(jump_en1), .jump_addr(jump_addr1), .irq_active(irq_active1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] e0, input logic [31:0] e1);
    addr_r = a;
    #1;
    chk({tag, "/d0"}, data_r0, e0);
    chk({tag, "/d1"}, data_r1, e1);
    $display("read %s addr=%0d d0=0x%08h d1=0x%08h", tag, a, data_r0, data_r1);
  endtask

  task automatic jchk(input string tag, input logic en, input logic [31:0] a0, input logic [31:0] a1);
    #1;
    chk({tag, "/en0"}, {31'b0, jump_en0}, {31'b0, en});
    chk({tag, "/en1"}, {31'b0, jump_en1}, {31'b0, en});
    chk({tag, "/ja0"}, jump_addr0, a0);
    chk({tag, "/ja1"}, jump_addr1, a1);
    $display("jump %s en=%0b/%0b a0=0x%08h a1=0x%08h", tag, jump_en0, jump_en1, jump_addr0, jump_addr1);
  endtask

  initial begin
    rst = 1'b1; oper = 2'b00; addr_r = 5'd0; addr_w = 5'd0; data_w = '0;
    ir_en = 1'b0; irq_in = '0; ret_addr = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    jchk("reset", 1'b0, 32'h0, 32'h0);
    rd("rst_epc", 5'd2, 32'h0, 32'h0);
    rd("rst_ehbr", 5'd3, 32'h100, 32'h200);
    rd("rst_status", 5'd12, 32'h0F01, 32'h0F01);
    rd("rst_cause", 5'd13, 32'h0, 32'h0);
    chk("rst_exl", {31'b0, irq_active0}, 32'h0);

    // Single line take and ERET
    irq_in = 4'b0001; ir_en = 1'b1; ret_addr = 32'h40;
    jchk("edge_cycle", 1'b0, 32'h0, 32'h0);
    tick();
    irq_in = 4'b0000;
    jchk("take0", 1'b1, 32'h100, 32'h200);
    tick();
    jchk("after_take0", 1'b0, 32'h100, 32'h200);
    rd("epc_40", 5'd2, 32'h40, 32'h40);
    rd("status_exl", 5'd12, 32'h0F03, 32'h0F03);
    rd("cause_ack0", 5'd13, 32'h0, 32'h0);
    chk("irq_active", {31'b0, irq_active1}, 32'h1);
    oper = 2'b11;
    jchk("eret1", 1'b1, 32'h40, 32'h40);
    tick();
    oper = 2'b00;
    jchk("after_eret1", 1'b0, 32'h40, 32'h40);
    rd("status_eret1", 5'd12, 32'h0F01, 32'h0F01);

    // Priority and vectoring: lines 3 and 1 rise together
    irq_in = 4'b1010; ret_addr = 32'h44;
    tick();
    jchk("take_pri1", 1'b1, 32'h100, 32'h210);
    tick();
    rd("cause_code1", 5'd13, 32'h0804, 32'h0804);
    rd("epc_44", 5'd2, 32'h44, 32'h44);
    oper = 2'b11;
    jchk("eret2", 1'b1, 32'h44, 32'h44);
    tick();
    oper = 2'b00; ret_addr = 32'h48;
    jchk("take_pri3", 1'b1, 32'h100, 32'h230);
    tick();
    rd("cause_code3", 5'd13, 32'h000C, 32'h000C);
    rd("epc_48", 5'd2, 32'h48, 32'h48);
    oper = 2'b11; irq_in = 4'b0000;
    tick();
    oper = 2'b00;

    // Masking
    oper = 2'b10; addr_w = 5'd12; data_w = 32'h0000_0001;
    rd("mtc0_no_bypass", 5'd12, 32'h0F01, 32'h0F01);
    tick();
    oper = 2'b00;
    rd("status_im0", 5'd12, 32'h0001, 32'h0001);
    irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    jchk("masked_nojump", 1'b0, 32'h48, 32'h48);
    rd("cause_masked", 5'd13, 32'h040C, 32'h040C);
    oper = 2'b10; addr_w = 5'd12; data_w = 32'h0000_0401;
    jchk("unmask_write_cycle", 1'b0, 32'h48, 32'h48);
    tick();
    oper = 2'b00; ret_addr = 32'h50;
    jchk("take_unmasked2", 1'b1, 32'h100, 32'h220);
    tick();
    rd("epc_50", 5'd2, 32'h50, 32'h50);
    rd("cause_code2", 5'd13, 32'h0008, 32'h0008);

    // Nesting blocked while EXL=1
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    jchk("nest_block", 1'b0, 32'h100, 32'h220);
    rd("cause_nest", 5'd13, 32'h0108, 32'h0108);
    oper = 2'b10; addr_w = 5'd12; data_w = 32'h0000_0F03;
    tick();
    oper = 2'b00;
    jchk("nest_still_block", 1'b0, 32'h100, 32'h220);
    rd("status_f03", 5'd12, 32'h0F03, 32'h0F03);
    oper = 2'b11;
    jchk("eret_nest", 1'b1, 32'h50, 32'h50);
    tick();
    // Take collides with an MTC0 to EPC
    oper = 2'b10; addr_w = 5'd2; data_w = 32'h999; ret_addr = 32'h60;
    jchk("take_collide", 1'b1, 32'h100, 32'h200);
    tick();
    oper = 2'b00;
    rd("epc_collide", 5'd2, 32'h60, 32'h60);
    rd("status_reentry", 5'd12, 32'h0F03, 32'h0F03);
    rd("cause_reentry", 5'd13, 32'h0, 32'h0);

    // W1C vs rising edge on line 1
    irq_in = 4'b0010;
    tick();
    irq_in = 4'b0000;
    tick();
    rd("cause_ip1", 5'd13, 32'h0200, 32'h0200);
    irq_in = 4'b0010; oper = 2'b10; addr_w = 5'd13; data_w = 32'h0000_0200;
    tick();
    oper = 2'b00;
    rd("w1c_vs_edge", 5'd13, 32'h0200, 32'h0200);
    oper = 2'b10;
    tick();
    oper = 2'b00;
    rd("w1c_clear", 5'd13, 32'h0, 32'h0);

    // Unmapped address and EHBR write
    rd("unmapped", 5'd5, 32'h0, 32'h0);
    oper = 2'b10; addr_w = 5'd3; data_w = 32'h300;
    tick();
    oper = 2'b00;
    rd("ehbr_write", 5'd3, 32'h300, 32'h300);

    // Reset mid-handler with all lines pending
    irq_in = 4'b0000;
    tick();
    irq_in = 4'b1111;
    tick();
    rd("pre_rst_cause", 5'd13, 32'h0F00, 32'h0F00);
    rd("pre_rst_status", 5'd12, 32'h0F03, 32'h0F03);
    rst = 1'b1; irq_in = 4'b0000;
    tick();
    rst = 1'b0;
    jchk("post_rst", 1'b0, 32'h0, 32'h0);
    rd("post_rst_status", 5'd12, 32'h0F01, 32'h0F01);
    rd("post_rst_cause", 5'd13, 32'h0, 32'h0);
    rd("post_rst_ehbr", 5'd3, 32'h100, 32'h200);
    rd("post_rst_epc", 5'd2, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_irq_ctrl.md
Name: cp0_irq_ctrl

Overview:
- Parametrised successor of the single-line CP0 block.
- Provides N-line interrupt handling: per-line edge capture, a maskable pending register, fixed-priority selection, and optional vectored dispatch.
- Holds the CP0 registers EPC, EHBR, Status and Cause, accessed by MFC0/MTC0. Reads happen in ID; writes and ERET happen in EXE.
- Drives the pipeline's forced-jump path for interrupt entry and for ERET.

Parameters:
- NUM_IRQ, 4: number of external interrupt lines, 1..8.
- VECTORED, 0: 1 = per-line handler addresses; 0 = single handler at EHBR.
- VEC_SHIFT, 4: vector spacing is 2^VEC_SHIFT bytes.
- IE_RESET, 1: reset value of Status.IE.
- EHBR_RESET, 32'h0: reset value of EHBR.

Ports:
- clk  in  1  main clock
- rst  in  1  synchronous reset, active-high
- oper  in  2  CP0 operation: 00 none, 01 MFC0, 10 MTC0, 11 ERET
- addr_r  in  5  read register address
- data_r  out  32  read data, combinational from addr_r
- addr_w  in  5  write register address
- data_w  in  32  write data
- ir_en  in  1  pipeline permits interrupt this cycle (no stall/flush in flight)
- irq_in  in  NUM_IRQ  external interrupt lines, synchronous to clk
- ret_addr  in  32  PC to save into EPC on interrupt entry
- jump_en  out  1  forced jump request
- jump_addr  out  32  forced jump target
- irq_active  out  1  Status.EXL (handler running)

Behaviour:
- Register map:
  - addr 2: EPC, R/W.
  - addr 3: EHBR, R/W.
  - addr 12: Status. bit0 IE; bit1 EXL (R/W); bits[8+NUM_IRQ-1:8] IM. All other bits read 0.
  - addr 13: Cause. bits[8+NUM_IRQ-1:8] IP; bits[4:2] CODE (index of last taken line). Writing 1 to an IP bit clears it. CODE is read-only.
  - Any other address reads 0; writes to it are ignored.
- Reset values: EPC=0, EHBR=EHBR_RESET, IE=IE_RESET, EXL=0, IM=all ones, IP=0, CODE=0, edge history=0. With no interrupt pending, jump_en=0 and jump_addr=0.
- Edge capture:
  - irq_prev <= irq_in every cycle.
  - IP[i] sets on a rising edge of line i (irq_in[i] & ~irq_prev[i]), whether or not the line is masked.
  - A line held high sets IP only once.
- Interrupt take (combinational): take = ir_en & IE & ~EXL & |(IP & IM).
  - sel = lowest index i with IP[i] & IM[i]; lowest index has highest priority.
- When take=1:
  - Same cycle: jump_en=1. jump_addr = EHBR when VECTORED=0; otherwise EHBR + (sel << VEC_SHIFT), 32-bit wrap.
  - Next edge: EPC<=ret_addr, EXL<=1, CODE<=sel, IP[sel]<=0 (auto-acknowledge).
  - oper is ignored that cycle: no MTC0 write and no ERET.
- ERET (oper=11, take=0):
  - Same cycle: jump_en=1, jump_addr=EPC.
  - Next edge: EXL<=0.
  - ERET with EXL=0 still jumps to EPC.
- MTC0 (oper=10, take=0): the write takes effect at the next edge. MFC0 in the same cycle returns the old value (no bypass).
- data_r is valid for any oper; the pipeline uses it only for MFC0.
- Otherwise: jump_en=0 and jump_addr holds its last driven value (registered shadow, no latch).
- Simultaneous events on the same line:
  - Rising edge and W1C: the set wins.
  - Rising edge and auto-acknowledge on take: the set wins, so the line stays pending for the next entry.
- Nesting: blocked while EXL=1. Software may clear EXL via MTC0 to Status to allow re-entry.
- Masked pending lines stay in IP and are taken as soon as IM is set, provided IE=1, EXL=0 and ir_en=1.
- ir_en=0: a pending interrupt waits; its state is unchanged.
- rst mid-handler: all state returns to reset values; pending lines are lost.

Test Plan:
- Single line, VECTORED=0, EHBR=0x100. Pulse irq_in[0] with ir_en=1 and ret_addr=0x40 → jump_en=1 with jump_addr=0x100 in the take cycle; next cycle EPC=0x40, EXL=1, IP[0]=0. Then ERET → jump_addr=0x40 and EXL=0 one cycle later.
- Priority and vectoring, VECTORED=1, VEC_SHIFT=4, EHBR=0x200. Raise irq_in[3] and irq_in[1] on the same edge → first take jumps to 0x210 with CODE=1. After ERET, second take jumps to 0x230 with CODE=3.
- Masking. MTC0 Status with IM=0, IE=1; pulse irq_in[2] → no jump, Cause reads IP[2]=1 (0x0400). MTC0 Status with IM[2]=1 → take occurs in the cycle after that write.
- Nesting block. While EXL=1, pulse irq_in[0] → no jump, IP[0]=1. ERET, then next cycle with ir_en=1 → take occurs and EPC is updated.
- Collisions:
  - MTC0 EPC=0x999 in the same cycle as a take with ret_addr=0x80 → EPC=0x80.
  - W1C of IP[1] on the same edge as a rising edge of irq_in[1] → IP[1] remains 1.
- Reset. Assert rst while EXL=1 and IP=0xF (NUM_IRQ=4) → next cycle EXL=0, IP=0, IM=0xF, jump_en=0, EHBR=EHBR_RESET.
